// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and controller states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_MUL  = 2'b01,
        OP_NAND = 2'b10,
        OP_NOT  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Unsigned shift-add multiplier: one partial product per clock, WIDTH clocks per product.
// done/product are valid combinationally in the cycle of the last iteration.
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   b_sh;
    logic [CW-1:0]      count;

    assign acc_next = b_sh[0] ? (acc + a_sh) : acc;
    assign done     = busy && (count == LAST);
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            a_sh  <= {{WIDTH{1'b0}}, a};
            b_sh  <= b;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            acc  <= acc_next;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            // Fixed iteration count regardless of operand values keeps MUL latency constant.
            if (count == LAST) begin
                busy <= 1'b0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: ADD/NAND/NOT in one clock, MUL through the shift-add unit.
//   state | meaning
//   IDLE  | empty, ready for an operation
//   MUL   | multiplier iterating, input stalled
//   DONE  | result/flags presented, waiting for the sink
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               zero_flag,
    output logic               carry_flag
);

    state_e             state, state_n;
    logic [2*WIDTH-1:0] result_n;
    logic               zero_n, carry_n;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] single_res;
    logic               single_carry;
    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);

    always_comb begin
        single_res   = '0;
        single_carry = 1'b0;
        sum          = {1'b0, a} + {1'b0, b};
        case (op_e'(op))
            OP_ADD: begin
                single_res   = {{(WIDTH-1){1'b0}}, sum};
                single_carry = sum[WIDTH];
            end
            OP_NAND: single_res = {{WIDTH{1'b0}}, ~(a & b)};
            OP_NOT:  single_res = {{WIDTH{1'b0}}, ~a};
            default: single_res = '0;
        endcase
    end

    always_comb begin
        state_n   = state;
        result_n  = result;
        zero_n    = zero_flag;
        carry_n   = carry_flag;
        mul_start = 1'b0;
        case (state)
            IDLE, DONE: begin
                if ((state == DONE) && out_ready) begin
                    state_n = IDLE;
                end
                if (in_valid && in_ready) begin
                    if (op_e'(op) == OP_MUL) begin
                        mul_start = 1'b1;
                        state_n   = MUL;
                    end else begin
                        result_n = single_res;
                        zero_n   = (single_res == '0);
                        carry_n  = single_carry;
                        state_n  = DONE;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    result_n = mul_product;
                    zero_n   = (mul_product == '0);
                    carry_n  = 1'b0;
                    state_n  = DONE;
                end else if (!mul_busy) begin
                    // Multiplier lost its operation; fall back rather than wait forever.
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            result     <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            state      <= state_n;
            result     <= result_n;
            zero_flag  <= zero_n;
            carry_flag <= carry_n;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=8: directed vector table, handshake corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a, b;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero_flag, carry_flag;

    int total = 0;
    int bad   = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        z;
        logic        c;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=response", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_res(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int unsigned ux = x;
        int unsigned uy = y;
        logic [7:0] nx;
        case (o)
            2'b00:   return 16'(ux + uy);
            2'b01:   return 16'(ux * uy);
            2'b10:   begin nx = ~(x & y); return {8'h00, nx}; end
            default: begin nx = ~x;       return {8'h00, nx}; end
        endcase
    endfunction

    function automatic logic model_carry(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int unsigned s = int'(x) + int'(y);
        return (o == 2'b00) && (s > 255);
    endfunction

    // Present one operation, wait for acceptance and result; scramble inputs while busy.
    task automatic run_op(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                          output logic [15:0] r, output logic z, output logic c,
                          output int lat, output int low);
        int  guard;
        bit  taken;
        op = o; a = av; b = bv; in_valid = 1'b1;
        guard = 0; taken = 0;
        while (!taken && guard < 50) begin
            taken = in_ready;
            step();
            guard++;
        end
        in_valid = 1'b0;
        if (!taken) timeout_fail("accept");
        lat = 1; low = 0; guard = 0;
        while (!out_valid && guard < 50) begin
            if (!in_ready) low++;
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 2'($urandom);
            step();
            lat++;
            guard++;
        end
        if (!out_valid) timeout_fail("out_valid");
        r = result; z = zero_flag; c = carry_flag;
    endtask

    initial begin
        logic [15:0] r;
        logic        z, c;
        int          lat, low, seen;
        logic [1:0]  ro;
        logic [7:0]  ra, rb;

        vecs[0]  = '{2'b00, 8'hFF, 8'h01, 16'h0100, 1'b0, 1'b1};
        vecs[1]  = '{2'b00, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{2'b01, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 8'h0C, 8'h0A, 16'h0078, 1'b0, 1'b0};
        vecs[4]  = '{2'b10, 8'hF0, 8'hCC, 16'h003F, 1'b0, 1'b0};
        vecs[5]  = '{2'b11, 8'h00, 8'h55, 16'h00FF, 1'b0, 1'b0};
        vecs[6]  = '{2'b01, 8'h00, 8'h37, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{2'b00, 8'h80, 8'h80, 16'h0100, 1'b0, 1'b1};
        vecs[8]  = '{2'b11, 8'hFF, 8'h00, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{2'b01, 8'h10, 8'h10, 16'h0100, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 8'hFF, 8'hFF, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{2'b01, 8'h80, 8'h00, 16'h0000, 1'b1, 1'b0};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0;
        repeat (2) step();
        reset = 1'b0;
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero_flag, 0);
        chk("rst_carry", carry_flag, 0);
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, c, lat, low);
            chk($sformatf("vec%0d_result", i), r, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), z, vecs[i].z);
            chk($sformatf("vec%0d_carry", i), c, vecs[i].c);
            chk($sformatf("vec%0d_latency", i), lat, (vecs[i].op == 2'b01) ? 9 : 1);
            chk($sformatf("vec%0d_busy_cycles", i), low, (vecs[i].op == 2'b01) ? 8 : 0);
        end
        step();
        chk("idle_after_vectors", out_valid, 0);

        // Back-to-back single-cycle ops, one result per clock.
        op = 2'b10; a = 8'hF0; b = 8'hCC; in_valid = 1'b1;
        step();
        chk("b2b_nand_valid", out_valid, 1);
        chk("b2b_nand_result", result, 16'h003F);
        chk("b2b_in_ready", in_ready, 1);
        op = 2'b11; a = 8'h00;
        step();
        chk("b2b_not_valid", out_valid, 1);
        chk("b2b_not_result", result, 16'h00FF);
        chk("b2b_not_carry", carry_flag, 0);
        in_valid = 1'b0;
        step();
        chk("b2b_drain", out_valid, 0);

        // Sink stall: result held, new input ignored until out_ready returns.
        out_ready = 1'b0;
        op = 2'b00; a = 8'h12; b = 8'h34; in_valid = 1'b1;
        step();
        op = 2'b11; a = 8'h55; b = 8'h00;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_result", result, 16'h0046);
            chk("stall_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("stall_release_ready", in_ready, 1);
        step();
        chk("stall_next_result", result, 16'h00AA);
        chk("stall_next_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        chk("stall_drain", out_valid, 0);

        // Reset four clocks into a MUL aborts it without a result.
        op = 2'b01; a = 8'h07; b = 8'h05; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("abort_no_valid", seen, 0);
        chk("abort_result", result, 0);
        chk("abort_in_ready", in_ready, 1);
        run_op(2'b01, 8'h03, 8'h03, r, z, c, lat, low);
        chk("after_abort_result", r, 16'h0009);
        chk("after_abort_latency", lat, 9);

        // Random operations against the reference model, with idle gaps.
        for (int i = 0; i < 300; i++) begin
            ro = 2'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) step();
            end
            run_op(ro, ra, rb, r, z, c, lat, low);
            chk("rand_result", r, model_res(ro, ra, rb));
            chk("rand_zero", z, model_res(ro, ra, rb) == 16'h0000);
            chk("rand_carry", c, model_carry(ro, ra, rb));
            chk("rand_latency", lat, (ro == 2'b01) ? 9 : 1);
        end
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
